// File: rtl/ofu_pkg.sv
// rtl/ofu_pkg.sv - shared sizes, FSM state and lane data type for the operand fetch unit
// Purpose: geometry defaults (lanes, data width, registers, warps), derived address widths,
//          the fetch FSM state encoding and the per-lane data type.
// Ports:   none (package).
package ofu_pkg;
    localparam int NLANES        = 16;
    localparam int DW            = 64;
    localparam int NREGS         = 64;
    localparam int NWARPS        = 8;
    localparam int MAX_STALL_DEF = 2;
    localparam int WW            = $clog2(NWARPS);
    localparam int AW            = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_e;

    typedef logic [DW-1:0] lane_data_t;
endpackage

// File: rtl/ofu_if.sv
// rtl/ofu_if.sv - request, operand, writeback and register-file bus of the operand fetch unit
// Purpose: bundles every non-clock signal of operand_fetch_unit.
// Ports:   slave modport  = fetch unit side (drives req_ready, op_*, wb_ready, rf_* controls).
//          master modport = environment side (requests, execute, writeback, register file data).
interface ofu_if;
    import ofu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [WW-1:0]        req_warp;
    logic [AW-1:0]        req_rs0;
    logic [AW-1:0]        req_rs1;
    logic                 req_use_rs1;
    logic [NLANES-1:0]    req_mask;

    logic                 op_valid;
    logic                 op_ready;
    logic [WW-1:0]        op_warp;
    logic [NLANES-1:0]    op_mask;
    logic [NLANES*DW-1:0] op_a;
    logic [NLANES*DW-1:0] op_b;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [WW-1:0]        wb_warp;
    logic [AW-1:0]        wb_rd;
    logic [NLANES-1:0]    wb_mask;
    logic [NLANES*DW-1:0] wb_data;

    logic [WW-1:0]        rf_warp_selector;
    logic [NLANES-1:0]    rf_read_en_0;
    logic [NLANES-1:0]    rf_read_en_1;
    logic [AW-1:0]        rf_raddr_0;
    logic [AW-1:0]        rf_raddr_1;
    logic [NLANES-1:0]    rf_write_en;
    logic [AW-1:0]        rf_waddr;
    logic [NLANES*DW-1:0] rf_wdata;
    logic [NLANES*DW-1:0] rf_rdata_0;
    logic [NLANES*DW-1:0] rf_rdata_1;

    modport slave (
        input  req_valid, req_warp, req_rs0, req_rs1, req_use_rs1, req_mask,
        output req_ready,
        output op_valid, op_warp, op_mask, op_a, op_b,
        input  op_ready,
        input  wb_valid, wb_warp, wb_rd, wb_mask, wb_data,
        output wb_ready,
        output rf_warp_selector, rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
        output rf_write_en, rf_waddr, rf_wdata,
        input  rf_rdata_0, rf_rdata_1
    );

    modport master (
        output req_valid, req_warp, req_rs0, req_rs1, req_use_rs1, req_mask,
        input  req_ready,
        input  op_valid, op_warp, op_mask, op_a, op_b,
        output op_ready,
        output wb_valid, wb_warp, wb_rd, wb_mask, wb_data,
        input  wb_ready,
        input  rf_warp_selector, rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1,
        input  rf_write_en, rf_waddr, rf_wdata,
        output rf_rdata_0, rf_rdata_1
    );
endinterface

// File: rtl/ofu_lane_capture.sv
// rtl/ofu_lane_capture.sv - per-lane operand capture select
// Purpose: picks the value to register for one lane: zero for inactive lanes (and for
//          operand b when there is no second source), forwarded writeback data on a bypass hit,
//          otherwise the register file read data.
// Ports:   lane_en, use_b, fwd_a, fwd_b (select), rdata_a/rdata_b/wb_data (sources), cap_a/cap_b (result).
module ofu_lane_capture
    import ofu_pkg::*;
(
    input  logic       lane_en,
    input  logic       use_b,
    input  logic       fwd_a,
    input  logic       fwd_b,
    input  lane_data_t rdata_a,
    input  lane_data_t rdata_b,
    input  lane_data_t wb_data,
    output lane_data_t cap_a,
    output lane_data_t cap_b
);
    always_comb begin
        cap_a = '0;
        cap_b = '0;
        if (lane_en) begin
            cap_a = fwd_a ? wb_data : rdata_a;
            if (use_b) begin
                cap_b = fwd_b ? wb_data : rdata_b;
            end
        end
    end
endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - operand fetch FSM, RF read/write port owner and warp_selector arbiter
// Purpose: accepts one fetch request per warp instruction, reads rs0/rs1 for all lanes in a single
//          READ cycle, holds operands for execute, and passes writebacks to the register file.
//          Writebacks to another warp win the shared warp_selector; after MAX_STALL such stalls the
//          read is forced through and the writeback is held off for that cycle.
// Ports:   clk, rst (synchronous, active-high), bus (ofu_if.slave).
// Config:  OFU_BYPASS_EN - when defined, a same-warp writeback hitting a source register in the
//          READ cycle is forwarded into the captured operand; otherwise the read waits one cycle.
module operand_fetch_unit
    import ofu_pkg::*;
#(
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic  clk,
    input  logic  rst,
    ofu_if.slave  bus
);
    localparam int SW = $clog2(MAX_STALL + 1);

    state_e               state_q, state_d;
    logic [WW-1:0]        warp_q, warp_d;
    logic [AW-1:0]        rs0_q, rs0_d;
    logic [AW-1:0]        rs1_q, rs1_d;
    logic                 use_rs1_q, use_rs1_d;
    logic [NLANES-1:0]    mask_q, mask_d;
    logic [WW-1:0]        op_warp_q, op_warp_d;
    logic [NLANES-1:0]    op_mask_q, op_mask_d;
    logic [NLANES*DW-1:0] op_a_q, op_a_d;
    logic [NLANES*DW-1:0] op_b_q, op_b_d;
    logic [WW-1:0]        sel_q, sel_d;
    logic [SW-1:0]        stall_cnt_q, stall_cnt_d;

    logic [NLANES*DW-1:0] cap_a, cap_b;
    logic in_read, same_warp, hit_a, hit_b, raw_stall, conflict, force_read;
    logic read_go, wb_accept, req_accept, fwd_a, fwd_b;

    always_comb begin
        in_read   = !rst && (state_q == READ);
        same_warp = (bus.wb_warp == warp_q);
        hit_a     = same_warp && (bus.wb_rd == rs0_q);
        hit_b     = same_warp && use_rs1_q && (bus.wb_rd == rs1_q);
`ifdef OFU_BYPASS_EN
        raw_stall = 1'b0;
`else
        raw_stall = hit_a || hit_b;
`endif
        // A writeback that cannot share this cycle with the read costs the read one cycle.
        conflict   = in_read && bus.wb_valid && (!same_warp || raw_stall);
        force_read = conflict && (stall_cnt_q == SW'(MAX_STALL));
        read_go    = in_read && (!conflict || force_read);

        bus.wb_ready  = !rst && !force_read;
        wb_accept     = bus.wb_valid && bus.wb_ready;
        bus.req_ready = !rst && ((state_q == IDLE) || ((state_q == VALID) && bus.op_ready));
        req_accept    = bus.req_valid && bus.req_ready;

`ifdef OFU_BYPASS_EN
        fwd_a = read_go && wb_accept && hit_a;
        fwd_b = read_go && wb_accept && hit_b;
`else
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`endif

        bus.rf_read_en_0 = read_go ? mask_q : '0;
        bus.rf_read_en_1 = (read_go && use_rs1_q) ? mask_q : '0;
        bus.rf_raddr_0   = rs0_q;
        bus.rf_raddr_1   = rs1_q;
        bus.rf_write_en  = wb_accept ? bus.wb_mask : '0;
        bus.rf_waddr     = bus.wb_rd;
        bus.rf_wdata     = bus.wb_data;

        // When both a write and a read go together they are the same warp, so either source works.
        sel_d = sel_q;
        if (wb_accept) begin
            sel_d = bus.wb_warp;
        end else if (read_go) begin
            sel_d = warp_q;
        end
        bus.rf_warp_selector = sel_d;

        state_d     = state_q;
        warp_d      = warp_q;
        rs0_d       = rs0_q;
        rs1_d       = rs1_q;
        use_rs1_d   = use_rs1_q;
        mask_d      = mask_q;
        op_warp_d   = op_warp_q;
        op_mask_d   = op_mask_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_accept) state_d = READ;
            end
            READ: begin
                if (read_go) begin
                    state_d     = VALID;
                    op_a_d      = cap_a;
                    op_b_d      = cap_b;
                    op_warp_d   = warp_q;
                    op_mask_d   = mask_q;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
            end
            VALID: begin
                if (bus.op_ready) state_d = req_accept ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (req_accept) begin
            warp_d    = bus.req_warp;
            rs0_d     = bus.req_rs0;
            rs1_d     = bus.req_rs1;
            use_rs1_d = bus.req_use_rs1;
            mask_d    = bus.req_mask;
        end
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        ofu_lane_capture u_capture (
            .lane_en (mask_q[i]),
            .use_b   (use_rs1_q),
            .fwd_a   (fwd_a && bus.wb_mask[i]),
            .fwd_b   (fwd_b && bus.wb_mask[i]),
            .rdata_a (bus.rf_rdata_0[i*DW +: DW]),
            .rdata_b (bus.rf_rdata_1[i*DW +: DW]),
            .wb_data (bus.wb_data[i*DW +: DW]),
            .cap_a   (cap_a[i*DW +: DW]),
            .cap_b   (cap_b[i*DW +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            warp_q      <= '0;
            rs0_q       <= '0;
            rs1_q       <= '0;
            use_rs1_q   <= 1'b0;
            mask_q      <= '0;
            op_warp_q   <= '0;
            op_mask_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sel_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            warp_q      <= warp_d;
            rs0_q       <= rs0_d;
            rs1_q       <= rs1_d;
            use_rs1_q   <= use_rs1_d;
            mask_q      <= mask_d;
            op_warp_q   <= op_warp_d;
            op_mask_q   <= op_mask_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sel_q       <= sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.op_valid = (state_q == VALID);
    assign bus.op_warp  = op_warp_q;
    assign bus.op_mask  = op_mask_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed self-checking bench for operand_fetch_unit
module tb_operand_fetch_unit;
    import ofu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ofu_if bus ();

    operand_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rfv(input int w, input int r, input int l);
        return {16'hCAFE, 16'(w), 16'(r), 16'(l)};
    endfunction

    function automatic logic [63:0] lane(input logic [NLANES*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    // Register file model: combinational read, disabled lanes return junk so gating errors show.
    logic [DW-1:0] rf_mem [NWARPS][NREGS][NLANES];
    localparam logic [DW-1:0] JUNK = 64'hDEAD_DEAD_DEAD_DEAD;

    always_comb begin
        bus.rf_rdata_0 = '0;
        bus.rf_rdata_1 = '0;
        for (int i = 0; i < NLANES; i++) begin
            bus.rf_rdata_0[i*DW +: DW] = bus.rf_read_en_0[i] ?
                rf_mem[bus.rf_warp_selector][bus.rf_raddr_0][i] : JUNK;
            bus.rf_rdata_1[i*DW +: DW] = bus.rf_read_en_1[i] ?
                rf_mem[bus.rf_warp_selector][bus.rf_raddr_1][i] : JUNK;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NLANES; i++) begin
            if (bus.rf_write_en[i]) begin
                rf_mem[bus.rf_warp_selector][bus.rf_waddr][i] <= bus.rf_wdata[i*DW +: DW];
            end
        end
    end

    task automatic set_wb(input logic v, input int w, input int rd, input logic [63:0] base);
        bus.wb_valid = v;
        bus.wb_warp  = WW'(w);
        bus.wb_rd    = AW'(rd);
        bus.wb_mask  = '1;
        for (int i = 0; i < NLANES; i++) bus.wb_data[i*DW +: DW] = base + 64'(i);
    endtask

    // Presents a request at the current negedge; returns at the negedge of the READ cycle.
    task automatic accept_req(input int w, input int rs0, input int rs1, input logic use1,
                              input logic [NLANES-1:0] mask);
        bus.req_valid   = 1'b1;
        bus.req_warp    = WW'(w);
        bus.req_rs0     = AW'(rs0);
        bus.req_rs1     = AW'(rs1);
        bus.req_use_rs1 = use1;
        bus.req_mask    = mask;
        #1 check("req_ready_accept", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic consume();
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        #1 check("op_valid_after_consume", bus.op_valid, 1'b0);
    endtask

    initial begin
        for (int w = 0; w < NWARPS; w++)
            for (int r = 0; r < NREGS; r++)
                for (int l = 0; l < NLANES; l++)
                    rf_mem[w][r][l] = rfv(w, r, l);
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_warp = '0; bus.req_rs0 = '0; bus.req_rs1 = '0;
        bus.req_use_rs1 = 1'b0; bus.req_mask = '0; bus.op_ready = 1'b0;
        set_wb(1'b0, 0, 0, 64'h0);
        repeat (2) @(negedge clk);

        // reset state
        check("rst_op_valid", bus.op_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_wb_ready", bus.wb_ready, 1'b0);
        check("rst_write_en", bus.rf_write_en, '0);
        check("rst_read_en_0", bus.rf_read_en_0, '0);
        check("rst_op_mask", bus.op_mask, '0);
        check("rst_op_a0", lane(bus.op_a, 0), 64'h0);
        rst = 1'b0;
        #1 check("req_ready_after_rst", bus.req_ready, 1'b1);
        check("wb_ready_after_rst", bus.wb_ready, 1'b1);

        // writeback warp0 r5 = lane*0x11, then fetch rs0=5 rs1=6
        bus.wb_valid = 1'b1; bus.wb_warp = 3'd0; bus.wb_rd = 6'd5; bus.wb_mask = '1;
        for (int i = 0; i < NLANES; i++) bus.wb_data[i*DW +: DW] = 64'(i * 'h11);
        #1 check("t1_wb_ready", bus.wb_ready, 1'b1);
        check("t1_write_en", bus.rf_write_en, 16'hFFFF);
        check("t1_waddr", bus.rf_waddr, 6'd5);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        accept_req(0, 5, 6, 1'b1, 16'hFFFF);
        #1 check("t1_read_op_valid", bus.op_valid, 1'b0);
        check("t1_read_en_0", bus.rf_read_en_0, 16'hFFFF);
        check("t1_read_en_1", bus.rf_read_en_1, 16'hFFFF);
        check("t1_raddr_0", bus.rf_raddr_0, 6'd5);
        check("t1_raddr_1", bus.rf_raddr_1, 6'd6);
        check("t1_write_en_idle", bus.rf_write_en, '0);
        @(negedge clk);
        check("t1_op_valid", bus.op_valid, 1'b1);
        check("t1_op_warp", bus.op_warp, 3'd0);
        check("t1_op_mask", bus.op_mask, 16'hFFFF);
        for (int i = 0; i < NLANES; i++) begin
            check($sformatf("t1_op_a%0d", i), lane(bus.op_a, i), 64'(i * 'h11));
            check($sformatf("t1_op_b%0d", i), lane(bus.op_b, i), rfv(0, 6, i));
        end
        consume();

        // partial mask, single source
        accept_req(1, 3, 8, 1'b0, 16'h00F0);
        #1 check("t2_read_en_0", bus.rf_read_en_0, 16'h00F0);
        check("t2_read_en_1", bus.rf_read_en_1, 16'h0000);
        @(negedge clk);
        check("t2_op_valid", bus.op_valid, 1'b1);
        for (int i = 0; i < NLANES; i++) begin
            check($sformatf("t2_op_a%0d", i), lane(bus.op_a, i),
                  (i >= 4 && i <= 7) ? rfv(1, 3, i) : 64'h0);
            check($sformatf("t2_op_b%0d", i), lane(bus.op_b, i), 64'h0);
        end

        // execute back-pressure, then back-to-back request
        bus.req_valid = 1'b1; bus.req_warp = 3'd2; bus.req_rs0 = 6'd7; bus.req_rs1 = 6'd0;
        bus.req_use_rs1 = 1'b0; bus.req_mask = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            #1 check("t3_hold_op_valid", bus.op_valid, 1'b1);
            check("t3_hold_req_ready", bus.req_ready, 1'b0);
            check("t3_hold_op_a5", lane(bus.op_a, 5), rfv(1, 3, 5));
            check("t3_hold_op_warp", bus.op_warp, 3'd1);
            check("t3_hold_op_mask", bus.op_mask, 16'h00F0);
            @(negedge clk);
        end
        bus.op_ready = 1'b1;
        #1 check("t3_b2b_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.op_ready = 1'b0; bus.req_valid = 1'b0;
        #1 check("t3_b2b_op_valid", bus.op_valid, 1'b0);
        check("t3_b2b_read_en_0", bus.rf_read_en_0, 16'hFFFF);
        check("t3_b2b_warp_sel", bus.rf_warp_selector, 3'd2);
        @(negedge clk);
        check("t3_b2b_valid", bus.op_valid, 1'b1);
        check("t3_b2b_warp", bus.op_warp, 3'd2);
        check("t3_b2b_a0", lane(bus.op_a, 0), rfv(2, 7, 0));
        check("t3_b2b_a15", lane(bus.op_a, 15), rfv(2, 7, 15));
        consume();

        // other-warp writeback every cycle: two stalls then forced read
        set_wb(1'b1, 3, 10, 64'hBEEF_0000_0000_0000);
        accept_req(2, 1, 0, 1'b0, 16'hFFFF);
        #1 check("t4_s1_wb_ready", bus.wb_ready, 1'b1);
        check("t4_s1_read_en", bus.rf_read_en_0, '0);
        check("t4_s1_warp_sel", bus.rf_warp_selector, 3'd3);
        check("t4_s1_op_valid", bus.op_valid, 1'b0);
        @(negedge clk);
        check("t4_s2_wb_ready", bus.wb_ready, 1'b1);
        check("t4_s2_read_en", bus.rf_read_en_0, '0);
        check("t4_s2_op_valid", bus.op_valid, 1'b0);
        @(negedge clk);
        check("t4_force_wb_ready", bus.wb_ready, 1'b0);
        check("t4_force_read_en", bus.rf_read_en_0, 16'hFFFF);
        check("t4_force_write_en", bus.rf_write_en, '0);
        check("t4_force_warp_sel", bus.rf_warp_selector, 3'd2);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        check("t4_op_valid", bus.op_valid, 1'b1);
        check("t4_op_a3", lane(bus.op_a, 3), rfv(2, 1, 3));
        check("t4_wb_written", rf_mem[3][10][4], 64'hBEEF_0000_0000_0004);
        consume();

        // read-after-write hazard on the same warp
        accept_req(1, 9, 0, 1'b0, 16'hFFFF);
        set_wb(1'b1, 1, 9, 64'hA5A5_0000_0000_0000);
        #1 check("t5_wb_ready", bus.wb_ready, 1'b1);
        check("t5_write_en", bus.rf_write_en, 16'hFFFF);
`ifdef OFU_BYPASS_EN
        check("t5_read_en", bus.rf_read_en_0, 16'hFFFF);
        @(negedge clk);
        bus.wb_valid = 1'b0;
`else
        check("t5_read_en_stall", bus.rf_read_en_0, '0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1 check("t5_stall_op_valid", bus.op_valid, 1'b0);
        check("t5_retry_read_en", bus.rf_read_en_0, 16'hFFFF);
        @(negedge clk);
`endif
        check("t5_op_valid", bus.op_valid, 1'b1);
        for (int i = 0; i < NLANES; i += 5)
            check($sformatf("t5_op_a%0d", i), lane(bus.op_a, i), 64'hA5A5_0000_0000_0000 + 64'(i));
        consume();

        // reset during READ with a writeback pending
        accept_req(0, 2, 0, 1'b0, 16'hFFFF);
        rst = 1'b1;
        set_wb(1'b1, 0, 20, 64'h0);
        #1 check("t6_rst_write_en", bus.rf_write_en, '0);
        check("t6_rst_wb_ready", bus.wb_ready, 1'b0);
        @(negedge clk);
        check("t6_op_valid", bus.op_valid, 1'b0);
        check("t6_write_en", bus.rf_write_en, '0);
        check("t6_req_ready", bus.req_ready, 1'b0);
        check("t6_read_en", bus.rf_read_en_0, '0);
        rst = 1'b0;
        bus.wb_valid = 1'b0;
        #1 check("t6_req_ready_rel", bus.req_ready, 1'b1);
        @(negedge clk);
        check("t6_dropped", bus.op_valid, 1'b0);
        check("t6_no_write", rf_mem[0][20][0], rfv(0, 20, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
